// File: rtl/expr_stream_gen_if.sv
// Request and character-stream bundle for the expression stream generator.
// The master side is the generator itself.
interface expr_stream_gen_if #(parameter int MAX_TERMS = 4);
  logic                   start;
  logic [3:0]             num_terms;
  logic [4*MAX_TERMS-1:0] digits;
  logic [MAX_TERMS-2:0]   ops;
  logic [7:0]             out_char;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    input  start, num_terms, digits, ops, out_ready,
    output out_char, out_valid, busy, done, err
  );

  modport slave (
    output start, num_terms, digits, ops, out_ready,
    input  out_char, out_valid, busy, done, err
  );
endinterface

// File: rtl/expr_stream_gen.sv
// Serialises a latched request of N BCD operands and N-1 operators into an
// ASCII "d0 op0 d1 ... d(N-1)" stream over a valid/ready byte interface.
module expr_stream_gen #(
  parameter int MAX_TERMS = 4
) (
  input  logic             clk,
  input  logic             clr,
  expr_stream_gen_if.master bus
);
  typedef enum logic [1:0] {IDLE, DIGIT, OP, FIN} state_t;

  // Operands and ops are zero-padded to the 4-bit index range so a 4-bit
  // index selects exactly without width juggling.
  typedef struct packed {
    logic [3:0]  n;
    logic [63:0] digits;
    logic [15:0] ops;
  } req_t;

  state_t      state;
  req_t        req;
  logic [3:0]  idx;
  logic [7:0]  out_char;
  logic        out_valid, busy, done, err;
  logic        bad;
  logic [63:0] in_digits;

  assign in_digits = 64'(bus.digits);

  // Only operands inside the requested count take part in the range check.
  always_comb begin
    bad = (bus.num_terms == 4'd0) || (int'(bus.num_terms) > MAX_TERMS);
    for (int i = 0; i < MAX_TERMS; i++)
      if (i < int'(bus.num_terms) && in_digits[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  function automatic logic [7:0] dchar(logic [63:0] d, logic [3:0] k);
    return 8'h30 + {4'h0, d[{k, 2'b00} +: 4]};
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      req       <= '0;
      idx       <= '0;
      out_char  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (bad) err <= 1'b1;
          else begin
            req       <= '{n: bus.num_terms, digits: in_digits, ops: 16'(bus.ops)};
            idx       <= '0;
            out_char  <= dchar(in_digits, 4'd0);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= DIGIT;
          end
        end
        DIGIT: if (bus.out_ready) begin
          if (idx == req.n - 4'd1) begin
            out_char  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= FIN;
          end else begin
            out_char <= req.ops[idx] ? 8'h2A : 8'h2B;
            state    <= OP;
          end
        end
        OP: if (bus.out_ready) begin
          idx      <= idx + 4'd1;
          out_char <= dchar(req.digits, idx + 4'd1);
          state    <= DIGIT;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_char  = out_char;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err;
endmodule

// File: tb/tb_expr_stream_gen.sv
// Directed bench for expr_stream_gen: a queue-based expression model checked
// every cycle, plus literal expected strings for each scenario.
module tb_expr_stream_gen;
  localparam int MT = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  expr_stream_gen_if #(.MAX_TERMS(MT)) ifc();
  expr_stream_gen #(.MAX_TERMS(MT)) dut (.clk(clk), .clr(clr), .bus(ifc.master));

  int n_chk = 0, n_fail = 0;
  int ndone = 0, nerr = 0;
  byte unsigned mq[$];   // characters the model still owes
  byte unsigned rx[$];   // characters actually transferred
  bit m_fin = 0, m_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(string name, string want);
    string got = "";
    bit ok;
    foreach (rx[i]) got = {got, $sformatf("%c", rx[i])};
    ok = (rx.size() == want.len());
    for (int i = 0; ok && i < want.len(); i++) if (rx[i] != want[i]) ok = 0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, want);
    end
  endtask

  function automatic bit req_ok(logic [3:0] n, logic [15:0] d);
    if (n == 0 || int'(n) > MT) return 0;
    for (int i = 0; i < int'(n); i++) if (d[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  // Model: an accepted request becomes the full expression string at once;
  // each transfer consumes one character, the empty queue means a done cycle.
  logic       e_valid, e_busy;
  logic [7:0] e_char;
  bit         nf, ne;
  initial forever begin
    @(negedge clk);
    if (!clr) begin
      e_valid = mq.size() > 0;
      e_char  = e_valid ? mq[0] : 8'h00;
      e_busy  = e_valid || m_fin;
      chk("out_valid", 32'(ifc.out_valid), 32'(e_valid));
      chk("out_char",  32'(ifc.out_char),  32'(e_char));
      chk("busy",      32'(ifc.busy),      32'(e_busy));
      chk("done",      32'(ifc.done),      32'(m_fin));
      chk("err",       32'(ifc.err),       32'(m_err));
      if (ifc.done === 1'b1) ndone++;
      if (ifc.err === 1'b1) nerr++;
      nf = 0; ne = 0;
      if (!e_busy && ifc.start) begin
        if (req_ok(ifc.num_terms, 16'(ifc.digits))) begin
          for (int i = 0; i < int'(ifc.num_terms); i++) begin
            mq.push_back(8'h30 + 8'(ifc.digits[4*i +: 4]));
            if (i < int'(ifc.num_terms) - 1) mq.push_back(ifc.ops[i] ? 8'h2A : 8'h2B);
          end
        end else ne = 1;
      end else if (e_valid && ifc.out_ready) begin
        rx.push_back(ifc.out_char);
        void'(mq.pop_front());
        if (mq.size() == 0) nf = 1;
      end
      m_fin = nf;
      m_err = ne;
    end
  end

  task automatic go(logic [3:0] n, logic [15:0] d, logic [2:0] o);
    ifc.num_terms = n; ifc.digits = d; ifc.ops = o; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int k = 0;
    while (ifc.busy === 1'b1 && k < 60) begin @(posedge clk); #1; k++; end
    chk({name, " finished"}, 32'(k < 60), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic stream(string name, logic [3:0] n, logic [15:0] d, logic [2:0] o, string want);
    int d0 = ndone;
    rx.delete();
    go(n, d, o);
    wait_idle(name);
    chk_str(name, want);
    chk({name, " done count"}, ndone - d0, 1);
  endtask

  task automatic reject(string name, logic [3:0] n, logic [15:0] d);
    int e0 = nerr;
    rx.delete();
    go(n, d, 3'b000);
    repeat (3) begin @(posedge clk); #1; end
    chk({name, " err count"}, nerr - e0, 1);
    chk({name, " no chars"}, rx.size(), 0);
  endtask

  initial begin
    int d0, e0;
    bit pat [8] = '{1, 0, 0, 1, 0, 1, 1, 1};
    ifc.start = 0; ifc.num_terms = 0; ifc.digits = 0; ifc.ops = 0; ifc.out_ready = 1;
    #2;
    chk("reset out_valid", 32'(ifc.out_valid), 0);
    chk("reset out_char",  32'(ifc.out_char),  0);
    chk("reset busy",      32'(ifc.busy),      0);
    chk("reset done/err",  32'({ifc.done, ifc.err}), 0);
    #10 clr = 0;
    @(posedge clk); #1;

    stream("b2b 3+4*5", 4'd3, 16'h0543, 3'b010, "3+4*5");

    // Backpressure with a fixed ready pattern starting at the first valid cycle.
    rx.delete(); d0 = ndone;
    go(4'd3, 16'h0543, 3'b010);
    foreach (pat[i]) begin ifc.out_ready = pat[i]; @(posedge clk); #1; end
    ifc.out_ready = 1;
    wait_idle("backpressure");
    chk_str("backpressure", "3+4*5");
    chk("backpressure done count", ndone - d0, 1);

    stream("single 9", 4'd1, 16'h0009, 3'b000, "9");
    stream("full 0*1*2*3", 4'd4, 16'h3210, 3'b111, "0*1*2*3");

    reject("reject N=0", 4'd0, 16'h0000);
    reject("reject N=5", 4'd5, 16'h1111);
    reject("reject bad operand", 4'd2, 16'h00A0);
    stream("ignore beyond N", 4'd1, 16'h00F0, 3'b000, "0");

    // Start while busy, with the inputs changed after the accepted start.
    rx.delete(); d0 = ndone; e0 = nerr;
    go(4'd3, 16'h0543, 3'b010);
    ifc.num_terms = 4'd2; ifc.digits = 16'h0077; ifc.ops = 3'b001; ifc.start = 1;
    @(posedge clk); #1;
    ifc.start = 0;
    wait_idle("busy start");
    chk_str("busy start", "3+4*5");
    chk("busy start done count", ndone - d0, 1);
    chk("busy start no err", nerr - e0, 0);

    // Asynchronous clear after two transfers.
    rx.delete(); d0 = ndone;
    go(4'd3, 16'h0543, 3'b010);
    @(posedge clk); #1;
    @(posedge clk); #2;
    clr = 1; #1;
    chk("clr out_valid", 32'(ifc.out_valid), 0);
    chk("clr out_char",  32'(ifc.out_char),  0);
    chk("clr busy",      32'(ifc.busy),      0);
    chk("clr done",      32'(ifc.done),      0);
    mq.delete(); m_fin = 0; m_err = 0;
    #1 clr = 0;
    chk_str("partial before clr", "3+");
    repeat (3) begin @(posedge clk); #1; end
    chk("clr no done", ndone - d0, 0);
    stream("after clr 1*2", 4'd2, 16'h0021, 3'b001, "1*2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
